// File: rtl/icmp_ping.sv
// ICMP echo-request initiator: builds and sends one echo request, then matches the reply and measures RTT.
// Define ICMP_PING_VERIFY_EN to also require an exact payload and length in the reply before declaring a match.
module icmp_ping #(
  parameter logic [15:0] PAYLOAD_LEN    = 16'd32,
  parameter logic [15:0] IDENT          = 16'h4C32,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12500000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [47:0] target_mac,
  input  logic [31:0] target_ip,
  input  logic        rx_enable,
  input  logic [7:0]  rx_data,
  input  logic        tx_enable,
  output logic        tx_request,
  output logic        tx_active,
  output logic [7:0]  tx_data,
  output logic [15:0] length,
  output logic [47:0] destination_mac,
  output logic [31:0] destination_ip,
  output logic        busy,
  output logic        done,
  output logic        success,
  output logic [23:0] rtt,
  output logic [15:0] seq
);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    TXREQ,
    TX,
    WAIT,
    DONE
  } state_t;

  localparam logic [15:0] MSG_LEN = 16'd8 + PAYLOAD_LEN;

  state_t      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] acc_q, acc_d;
  logic [15:0] chk_q, chk_d;
  logic [23:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] seq_q, seq_d;
  logic        success_q, success_d;
  logic [23:0] rtt_q, rtt_d;
  logic [47:0] mac_q, mac_d;
  logic [31:0] ip_q, ip_d;
  logic [15:0] length_q, length_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic        rx_ok_q, rx_ok_d;

  logic [31:0] acc_sum;
  logic [16:0] fold;
  logic [15:0] chk_calc;
  logic [7:0]  tx_byte;
  logic [7:0]  tx_pay;
  logic        rx_byte_ok;
  logic        rx_match;

  // Payload byte i is i[7:0]; even positions land in the high byte of each 16-bit word.
  always_comb begin
    acc_sum  = acc_q + (idx_q[0] ? {24'h0, idx_q[7:0]} : {16'h0, idx_q[7:0], 8'h0});
    fold     = {1'b0, acc_sum[15:0]} + {1'b0, acc_sum[31:16]};
    chk_calc = ~(fold[15:0] + {15'h0, fold[16]});
  end

  always_comb begin
    tx_pay = idx_q[7:0] - 8'd8;
    case (idx_q)
      16'd0:   tx_byte = 8'h08;
      16'd1:   tx_byte = 8'h00;
      16'd2:   tx_byte = chk_q[15:8];
      16'd3:   tx_byte = chk_q[7:0];
      16'd4:   tx_byte = IDENT[15:8];
      16'd5:   tx_byte = IDENT[7:0];
      16'd6:   tx_byte = seq_q[15:8];
      16'd7:   tx_byte = seq_q[7:0];
      default: tx_byte = tx_pay;
    endcase
  end

`ifdef ICMP_PING_VERIFY_EN
  logic [7:0] rx_pay;
  assign rx_pay = rx_cnt_q[7:0] - 8'd8;
`endif

  always_comb begin
    case (rx_cnt_q)
      16'd0, 16'd1: rx_byte_ok = (rx_data == 8'h00);
      16'd2, 16'd3: rx_byte_ok = 1'b1;
      16'd4:        rx_byte_ok = (rx_data == IDENT[15:8]);
      16'd5:        rx_byte_ok = (rx_data == IDENT[7:0]);
      16'd6:        rx_byte_ok = (rx_data == seq_q[15:8]);
      16'd7:        rx_byte_ok = (rx_data == seq_q[7:0]);
`ifdef ICMP_PING_VERIFY_EN
      default:      rx_byte_ok = (rx_data == rx_pay);
`else
      default:      rx_byte_ok = 1'b1;
`endif
    endcase

    rx_cnt_d = '0;
    rx_ok_d  = rx_ok_q;
    if (rx_enable) begin
      rx_cnt_d = (rx_cnt_q == 16'hFFFF) ? rx_cnt_q : rx_cnt_q + 16'd1;
      rx_ok_d  = rx_byte_ok && ((rx_cnt_q == 16'd0) || rx_ok_q);
    end

`ifdef ICMP_PING_VERIFY_EN
    // Counter still holds the byte count on the first low cycle of rx_enable.
    rx_match = !rx_enable && (rx_cnt_q == MSG_LEN) && rx_ok_q;
`else
    rx_match = rx_enable && (rx_cnt_q == 16'd7) && rx_ok_q && rx_byte_ok;
`endif
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    chk_d      = chk_q;
    wait_cnt_d = wait_cnt_q;
    seq_d      = seq_q;
    success_d  = success_q;
    rtt_d      = rtt_q;
    mac_d      = mac_q;
    ip_d       = ip_q;
    length_d   = length_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mac_d     = target_mac;
          ip_d      = target_ip;
          success_d = 1'b0;
          rtt_d     = '0;
          length_d  = MSG_LEN;
          acc_d     = 32'h0000_0800 + {16'h0, IDENT} + {16'h0, seq_q};
          idx_d     = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        acc_d = acc_sum;
        idx_d = idx_q + 16'd1;
        if (idx_q == PAYLOAD_LEN - 16'd1) begin
          chk_d   = chk_calc;
          idx_d   = '0;
          state_d = TXREQ;
        end
      end
      TXREQ: begin
        if (tx_enable) begin
          idx_d   = 16'd1;
          state_d = TX;
        end
      end
      TX: begin
        idx_d = idx_q + 16'd1;
        if (idx_q == MSG_LEN - 16'd1) begin
          idx_d      = '0;
          wait_cnt_d = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + 24'd1;
        if (rx_match) begin
          rtt_d     = wait_cnt_q;
          success_d = 1'b1;
          state_d   = DONE;
        end else if (wait_cnt_q == TIMEOUT_CYCLES - 24'd1) begin
          success_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        seq_d   = seq_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      chk_q      <= '0;
      wait_cnt_q <= '0;
      seq_q      <= '0;
      success_q  <= 1'b0;
      rtt_q      <= '0;
      mac_q      <= '0;
      ip_q       <= '0;
      length_q   <= '0;
      rx_cnt_q   <= '0;
      rx_ok_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      chk_q      <= chk_d;
      wait_cnt_q <= wait_cnt_d;
      seq_q      <= seq_d;
      success_q  <= success_d;
      rtt_q      <= rtt_d;
      mac_q      <= mac_d;
      ip_q       <= ip_d;
      length_q   <= length_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_ok_q    <= rx_ok_d;
    end
  end

  // Byte 0 goes out in the same cycle the grant is seen, so tx_active follows tx_enable in TXREQ.
  assign tx_request      = (state_q == TXREQ) || (state_q == TX);
  assign tx_active       = (state_q == TX) || ((state_q == TXREQ) && tx_enable);
  assign tx_data         = tx_request ? tx_byte : '0;
  assign length          = length_q;
  assign destination_mac = mac_q;
  assign destination_ip  = ip_q;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign success         = success_q;
  assign rtt             = rtt_q;
  assign seq             = seq_q;

endmodule

// File: doc/icmp_ping.md
Name: icmp_ping

Overview:
- ICMP echo-request initiator; the requesting end of the echo exchange that the existing echo responder answers.
- On a start pulse, builds and transmits one echo request (type 8) through the standard tx_request/tx_enable/tx_active/tx_data arbiter interface.
- Then watches the ICMP receive byte stream for the matching echo reply (type 0) and reports success and round-trip time in clock cycles.
- Single clock domain; used for link self-test and for host reachability checks.

Parameters:
- PAYLOAD_LEN, 16'd32: echo payload bytes; legal range 1..1024.
- IDENT, 16'h4C32: ICMP identifier field.
- TIMEOUT_CYCLES, 24'd12500000: reply wait limit (100 ms at 125 MHz).

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request pulse.
- target_mac  in  48  latched into destination_mac at start.
- target_ip  in  32  latched into destination_ip at start.
- rx_enable  in  1  high for the duration of a received ICMP message.
- rx_data  in  8  ICMP bytes; type is the first byte.
- tx_enable  in  1  grant from the tx arbiter.
- tx_request  out  1  request to send.
- tx_active  out  1  bytes being sent.
- tx_data  out  8  ICMP byte.
- length  out  16  ICMP length, 8+PAYLOAD_LEN.
- destination_mac  out  48  latched target MAC.
- destination_ip  out  32  latched target IP.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle completion pulse.
- success  out  1  result of the last request.
- rtt  out  24  round-trip cycles of the last request.
- seq  out  16  sequence number of the next or current request.

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; seq=0; internal counters 0.
- Tx frame, in order: 08, 00, chk[15:8], chk[7:0], IDENT[15:8], IDENT[7:0], seq[15:8], seq[7:0], then payload byte i = i[7:0] for i = 0..PAYLOAD_LEN-1.
- States:
  - IDLE: on start, latch target_mac/target_ip, clear success and rtt, go to CALC. start is ignored in every other state.
  - CALC: one payload byte per cycle, PAYLOAD_LEN cycles.
    - 32-bit accumulator is preset to 0x0800+IDENT+seq.
    - Even index adds byte<<8; odd index adds byte.
    - Then go to TXREQ with chk = ~(f[15:0]+f[16]), where f = sum[15:0]+sum[31:16] (17-bit).
  - TXREQ:
    - tx_request=1; tx_data presents byte 0.
    - The cycle tx_enable is sampled high, byte 0 is consumed, tx_active=1, go to TX.
  - TX:
    - tx_active=1; byte index advances every cycle.
    - After byte length-1: drop tx_request and tx_active, clear the wait counter, go to WAIT.
  - WAIT:
    - Wait counter increments each cycle.
    - On reply match: rtt=counter, success=1, go to DONE.
    - When counter == TIMEOUT_CYCLES-1: success=0, go to DONE.
    - If match and timeout occur in the same cycle, match wins.
  - DONE: done=1 for one cycle, seq increments (wraps FFFF->0000), go to IDLE.
- Rx parser:
  - Byte counter runs while rx_enable is high; it is reset when rx_enable drops.
  - Match requires all of: type=00 (byte 0), code=00 (byte 1), bytes 4-5 = IDENT, bytes 6-7 = seq.
  - Checksum bytes are not checked.
  - Match is declared on the cycle byte 7 is accepted, and only while in WAIT.
- Rx boundary conditions:
  - Messages outside WAIT are ignored.
  - A mismatching message leaves the block waiting.
  - If rx_enable drops before byte 7, no match.
  - Receiving while transmitting is legal and is ignored.
- Reset mid-operation aborts immediately: tx_request and tx_active drop asynchronously.
- Outputs success, rtt and destination_* hold until the next start.

Optional Feature:
- ICMP_PING_VERIFY_EN defined:
  - The header match is only provisional.
  - Every payload byte must equal i[7:0], and rx_enable must fall after exactly PAYLOAD_LEN payload bytes.
  - Match is declared on the cycle rx_enable is first seen low; rtt is captured then.
  - A payload error is treated as a mismatch and waiting continues.
- ICMP_PING_VERIFY_EN undefined: header match at byte 7, as above.

Test Plan:
- PAYLOAD_LEN=4, seq=0, start, tx_enable granted 3 cycles after tx_request -> bytes 08 00 A9 C9 4C 32 00 00 00 01 02 03; length=12; tx_active high for exactly 12 cycles.
- Reply 00 00 xx xx 4C 32 00 00 + payload starting 20 cycles after the last tx byte -> success=1, rtt=27 (reply starts at counter 20, match declared on byte 7, counter 27); done pulses once; seq=1.
- Reply with sequence 00 05, then no valid reply, TIMEOUT_CYCLES=100 -> success=0 and done exactly 100 cycles after entering WAIT.
- start pulsed while busy, and a reply arriving in TXREQ -> both ignored; no second request; success unaffected.
- reset_n low during TX byte 5 -> tx_active and tx_request drop in the same cycle; next start transmits seq=0 again.
- With ICMP_PING_VERIFY_EN, reply payload byte 2 corrupted to FF -> no success; timeout -> success=0.
